// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer for the single-cycle RV32I core.
// It owns the M-mode trap CSRs and mcycle, and stalls the core and redirects the PC on traps and MRET.
module trap_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0004
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic            I_valid,
  input  logic [XLEN-1:0] I_pc,
  input  logic [XLEN-1:0] I_inst,
  input  logic            I_ecall,
  input  logic            I_ebreak,
  input  logic            I_illegalinst,
  input  logic            I_mret,
  input  logic            I_ext_irq,
  input  logic            I_timer_irq,
  input  logic            I_csr_we,
  input  logic [11:0]     I_csr_addr,
  input  logic [XLEN-1:0] I_csr_wdata,
  output logic [XLEN-1:0] O_csr_rdata,
  output logic            O_stall,
  output logic            O_pc_redirect,
  output logic [XLEN-1:0] O_pc_target
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'h B00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRAP_REDIR = 2'd1,
    RET_REDIR  = 2'd2
  } state_t;

  state_t          state;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_mtie;
  logic            mie_meie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [63:0]     mcycle;

  logic            idle_valid;
  logic            ext_take;
  logic            tim_take;
  logic            trap_take;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_tval;
  logic            mret_take;
  logic            csr_wr;

  assign idle_valid = (state == IDLE) && I_valid;
  assign ext_take   = mstatus_mie & mie_meie & I_ext_irq;
  assign tim_take   = mstatus_mie & mie_mtie & I_timer_irq;

  // Prioritised trap selection; synchronous exceptions beat interrupts.
  always_comb begin
    trap_take  = 1'b0;
    trap_cause = {XLEN{1'b0}};
    trap_tval  = {XLEN{1'b0}};
    if (!idle_valid) begin
      trap_take = 1'b0;
    end else if (I_illegalinst) begin
      trap_take  = 1'b1;
      trap_cause = 32'd2;
      trap_tval  = I_inst;
    end else if (I_ebreak) begin
      trap_take  = 1'b1;
      trap_cause = 32'd3;
      trap_tval  = I_pc;
    end else if (I_ecall) begin
      trap_take  = 1'b1;
      trap_cause = 32'd11;
    end else if (ext_take) begin
      trap_take  = 1'b1;
      trap_cause = 32'h8000_000B;
    end else if (tim_take) begin
      trap_take  = 1'b1;
      trap_cause = 32'h8000_0007;
    end else begin
      trap_take = 1'b0;
    end
  end

  assign mret_take = idle_valid & I_mret & ~trap_take;
  assign csr_wr    = idle_valid & I_csr_we & ~trap_take & ~mret_take;
  assign O_stall   = (state != IDLE) | trap_take | mret_take;

  // Combinational CSR read mux.
  always_comb begin
    O_csr_rdata = {XLEN{1'b0}};
    case (I_csr_addr)
      CSR_MSTATUS: begin
        O_csr_rdata[3] = mstatus_mie;
        O_csr_rdata[7] = mstatus_mpie;
      end
      CSR_MIE: begin
        O_csr_rdata[7]  = mie_mtie;
        O_csr_rdata[11] = mie_meie;
      end
      CSR_MTVEC:   O_csr_rdata = mtvec;
      CSR_MEPC:    O_csr_rdata = mepc;
      CSR_MCAUSE:  O_csr_rdata = mcause;
      CSR_MTVAL:   O_csr_rdata = mtval;
      CSR_MIP: begin
        O_csr_rdata[7]  = I_timer_irq;
        O_csr_rdata[11] = I_ext_irq;
      end
      CSR_MCYCLE:  O_csr_rdata = mcycle[31:0];
      CSR_MCYCLEH: O_csr_rdata = mcycle[63:32];
      default:     O_csr_rdata = {XLEN{1'b0}};
    endcase
  end

  // Sequencer FSM; the redirect target is captured on entry so it is stable for the redirect cycle.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state         <= IDLE;
      O_pc_redirect <= 1'b0;
      O_pc_target   <= {XLEN{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (trap_take) begin
            state         <= TRAP_REDIR;
            O_pc_redirect <= 1'b1;
            O_pc_target   <= mtvec;
          end else if (mret_take) begin
            state         <= RET_REDIR;
            O_pc_redirect <= 1'b1;
            O_pc_target   <= mepc;
          end else begin
            state         <= IDLE;
            O_pc_redirect <= 1'b0;
            O_pc_target   <= {XLEN{1'b0}};
          end
        end
        TRAP_REDIR, RET_REDIR: begin
          state         <= IDLE;
          O_pc_redirect <= 1'b0;
          O_pc_target   <= {XLEN{1'b0}};
        end
        default: begin
          state         <= IDLE;
          O_pc_redirect <= 1'b0;
          O_pc_target   <= {XLEN{1'b0}};
        end
      endcase
    end
  end

  // Trap CSR updates: trap entry, MRET, then software writes.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mepc         <= {XLEN{1'b0}};
      mcause       <= {XLEN{1'b0}};
      mtval        <= {XLEN{1'b0}};
    end else if (trap_take) begin
      mepc         <= {I_pc[XLEN-1:2], 2'b00};
      mcause       <= trap_cause;
      mtval        <= trap_tval;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_take) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_wr) begin
      case (I_csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= I_csr_wdata[3];
          mstatus_mpie <= I_csr_wdata[7];
        end
        CSR_MIE: begin
          mie_mtie <= I_csr_wdata[7];
          mie_meie <= I_csr_wdata[11];
        end
        CSR_MTVEC:  mtvec  <= {I_csr_wdata[XLEN-1:2], 2'b00};
        CSR_MEPC:   mepc   <= {I_csr_wdata[XLEN-1:2], 2'b00};
        CSR_MCAUSE: mcause <= I_csr_wdata;
        CSR_MTVAL:  mtval  <= I_csr_wdata;
        default:    mtval  <= mtval;
      endcase
    end else begin
      mtval <= mtval;
    end
  end

  // 64-bit cycle counter; a write to either half suppresses that cycle's increment.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      mcycle <= 64'd0;
    end else if (csr_wr && (I_csr_addr == CSR_MCYCLE)) begin
      mcycle[31:0] <= I_csr_wdata;
    end else if (csr_wr && (I_csr_addr == CSR_MCYCLEH)) begin
      mcycle[63:32] <= I_csr_wdata;
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer: reset, traps, interrupts, MRET and conflict cases.
module tb_trap_sequencer;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        ecall;
  logic        ebreak;
  logic        illegal;
  logic        mret;
  logic        ext_irq;
  logic        timer_irq;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] target;

  int vectors = 0;
  int miscompares = 0;

  trap_sequencer dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .I_valid       (valid),
    .I_pc          (pc),
    .I_inst        (inst),
    .I_ecall       (ecall),
    .I_ebreak      (ebreak),
    .I_illegalinst (illegal),
    .I_mret        (mret),
    .I_ext_irq     (ext_irq),
    .I_timer_irq   (timer_irq),
    .I_csr_we      (csr_we),
    .I_csr_addr    (csr_addr),
    .I_csr_wdata   (csr_wdata),
    .O_csr_rdata   (csr_rdata),
    .O_stall       (stall),
    .O_pc_redirect (redirect),
    .O_pc_target   (target)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check_eq(tag, csr_rdata, exp);
  endtask

  task automatic clear_inputs();
    valid = 1'b0; ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0; mret = 1'b0;
    csr_we = 1'b0; csr_wdata = 32'h0; inst = 32'h0000_0013;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    valid = 1'b1; csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
    step();
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1; pc = 32'h0; csr_addr = 12'h0; ext_irq = 1'b0; timer_irq = 1'b0;
    clear_inputs();
    step();
    step();
    rd_check("rst_mtvec", 12'h305, 32'h0000_0004);
    rd_check("rst_mstatus", 12'h300, 32'h0);
    rd_check("rst_mie", 12'h304, 32'h0);
    rd_check("rst_mepc", 12'h341, 32'h0);
    rd_check("rst_mcause", 12'h342, 32'h0);
    rd_check("rst_mtval", 12'h343, 32'h0);
    rd_check("rst_mip", 12'h344, 32'h0);
    rd_check("rst_mcycle", 12'hB00, 32'h0);
    check_eq("rst_redirect", {31'd0, redirect}, 32'd0);
    rst = 1'b0;
    repeat (10) step();
    rd_check("mcycle_10", 12'hB00, 32'd10);
    check_eq("idle_stall", {31'd0, stall}, 32'd0);

    // Illegal beats ecall in the same instruction.
    valid = 1'b1; pc = 32'h40; inst = 32'hFFFF_FFFF; illegal = 1'b1; ecall = 1'b1;
    #1;
    check_eq("ill_stall_n", {31'd0, stall}, 32'd1);
    check_eq("ill_noredir_n", {31'd0, redirect}, 32'd0);
    step();
    clear_inputs();
    #1;
    check_eq("ill_stall_n1", {31'd0, stall}, 32'd1);
    check_eq("ill_redir_n1", {31'd0, redirect}, 32'd1);
    check_eq("ill_target", target, 32'h4);
    step();
    check_eq("ill_redir_n2", {31'd0, redirect}, 32'd0);
    check_eq("ill_stall_n2", {31'd0, stall}, 32'd0);
    rd_check("ill_mepc", 12'h341, 32'h40);
    rd_check("ill_mcause", 12'h342, 32'd2);
    rd_check("ill_mtval", 12'h343, 32'hFFFF_FFFF);
    rd_check("ill_mstatus", 12'h300, 32'h0);

    // External interrupt.
    csr_write(12'h305, 32'h0000_0203);
    csr_write(12'h304, 32'h0000_0800);
    csr_write(12'h300, 32'h0000_0008);
    rd_check("wr_mtvec_masked", 12'h305, 32'h200);
    rd_check("wr_mie", 12'h304, 32'h800);
    rd_check("wr_mstatus", 12'h300, 32'h8);
    valid = 1'b1; pc = 32'h80; ext_irq = 1'b1;
    rd_check("ext_mip", 12'h344, 32'h800);
    check_eq("ext_stall_n", {31'd0, stall}, 32'd1);
    step();
    clear_inputs();
    #1;
    check_eq("ext_redir", {31'd0, redirect}, 32'd1);
    check_eq("ext_target", target, 32'h200);
    step();
    valid = 1'b1; pc = 32'h200;
    #1;
    check_eq("ext_held_stall", {31'd0, stall}, 32'd0);
    step();
    check_eq("ext_held_redir", {31'd0, redirect}, 32'd0);
    ext_irq = 1'b0;
    clear_inputs();
    rd_check("ext_mcause", 12'h342, 32'h8000_000B);
    rd_check("ext_mepc", 12'h341, 32'h80);
    rd_check("ext_mstatus", 12'h300, 32'h80);

    // MRET back to the interrupted PC.
    valid = 1'b1; pc = 32'h204; mret = 1'b1;
    #1;
    check_eq("mret_stall_n", {31'd0, stall}, 32'd1);
    step();
    clear_inputs();
    #1;
    check_eq("mret_redir", {31'd0, redirect}, 32'd1);
    check_eq("mret_target", target, 32'h80);
    step();
    check_eq("mret_redir_n2", {31'd0, redirect}, 32'd0);
    rd_check("mret_mstatus", 12'h300, 32'h88);

    // Ecall with a simultaneous mtvec write; then a second ecall during TRAP_REDIR.
    valid = 1'b1; pc = 32'h100; ecall = 1'b1; csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h300;
    step();
    pc = 32'h104; csr_wdata = 32'h400;
    #1;
    check_eq("cfl_redir", {31'd0, redirect}, 32'd1);
    check_eq("cfl_target", target, 32'h200);
    step();
    clear_inputs();
    #1;
    check_eq("cfl_redir_n2", {31'd0, redirect}, 32'd0);
    check_eq("cfl_stall_n2", {31'd0, stall}, 32'd0);
    rd_check("cfl_mtvec", 12'h305, 32'h200);
    rd_check("cfl_mepc", 12'h341, 32'h100);
    rd_check("cfl_mcause", 12'h342, 32'd11);
    rd_check("cfl_mtval", 12'h343, 32'h0);

    // mcycle write and carry into the high half.
    csr_write(12'hB80, 32'd5);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    rd_check("cyc_lo_written", 12'hB00, 32'hFFFF_FFFF);
    rd_check("cyc_hi_written", 12'hB80, 32'd5);
    step();
    rd_check("cyc_lo_wrap", 12'hB00, 32'h0);
    rd_check("cyc_hi_carry", 12'hB80, 32'd6);

    // Ebreak, then async reset in the middle of TRAP_REDIR.
    valid = 1'b1; pc = 32'h300; ebreak = 1'b1;
    step();
    clear_inputs();
    #1;
    check_eq("ebk_redir", {31'd0, redirect}, 32'd1);
    rd_check("ebk_mcause", 12'h342, 32'd3);
    rd_check("ebk_mtval", 12'h343, 32'h300);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_redir", {31'd0, redirect}, 32'd0);
    check_eq("arst_target", target, 32'h0);
    check_eq("arst_stall", {31'd0, stall}, 32'd0);
    rd_check("arst_mtvec", 12'h305, 32'h4);
    rd_check("arst_mepc", 12'h341, 32'h0);
    rd_check("arst_mcause", 12'h342, 32'h0);
    rst = 1'b0;
    step();
    check_eq("arst_idle_redir", {31'd0, redirect}, 32'd0);

    // Timer interrupt, then a masked timer interrupt after the trap.
    csr_write(12'h304, 32'h0000_0080);
    csr_write(12'h300, 32'h0000_0008);
    valid = 1'b1; pc = 32'h500; timer_irq = 1'b1;
    #1;
    check_eq("tim_stall_n", {31'd0, stall}, 32'd1);
    step();
    clear_inputs();
    #1;
    check_eq("tim_target", target, 32'h4);
    step();
    valid = 1'b1; pc = 32'h4;
    #1;
    check_eq("tim_masked_stall", {31'd0, stall}, 32'd0);
    rd_check("tim_mcause", 12'h342, 32'h8000_0007);
    rd_check("tim_mepc", 12'h341, 32'h500);
    timer_irq = 1'b0;
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
